spi_rx_word_fifo: RTL and testbench

//  Sits behind spi_slave in the clk domain. Assembles received SPI bytes into BYTES_PER_WORD-byte words, MSB byte first.

---
 rtl/spi_rx_word_fifo.sv | 173 +++++++++++++++++
 tb/tb_spi_rx_word_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_word_fifo.sv
// Assembles SPI bytes into MSB-first words framed by CSn and queues them in a
// first-word-fall-through FIFO with overflow counting and partial-frame flagging.
module spi_rx_word_fifo #(
  parameter int BYTES_PER_WORD = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_W          = 8,
  localparam int WW            = 8 * BYTES_PER_WORD,
  localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       i_rx_byte,
  input  logic             i_rx_dv,
  input  logic             i_csn,
  output logic [WW-1:0]    o_word,
  output logic             o_word_first,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic [LVL_W-1:0] o_level,
  output logic             o_frame_err,
  output logic [CNT_W-1:0] o_ovf_cnt,
  output logic [15:0]      o_last_bytes
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } state_e;

  logic             csn_meta_q, csn_s_q, csn_prev_q;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic             first_q, first_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [15:0]      last_bytes_q, last_bytes_d;
  logic [WW:0]      mem_q [FIFO_DEPTH];

  logic             csn_start, csn_end;
  logic             push, pop, push_ok, valid;
  logic [WW-1:0]    new_word;

  assign csn_start = csn_prev_q & ~csn_s_q;
  assign csn_end   = ~csn_prev_q & csn_s_q;

  // Only the bytes preceding the newest one need storage; the newest byte
  // completes the word straight from the input.
  if (BYTES_PER_WORD == 1) begin : g_single
    assign new_word = i_rx_byte;
  end else begin : g_multi
    logic [WW-9:0] asm_q;
    assign new_word = {asm_q, i_rx_byte};
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        asm_q <= '0;
      end else if (state_q == COLLECT && i_rx_dv) begin
        asm_q <= new_word[WW-9:0];
      end
    end
  end

  assign valid   = (level_q != '0);
  assign pop     = valid & i_word_ready;
  assign push_ok = (level_q != FULL_LVL) | pop;

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    first_d      = first_q;
    ovf_cnt_d    = ovf_cnt_q;
    last_bytes_d = last_bytes_q;
    frame_err_d  = 1'b0;
    push         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (csn_start) begin
          state_d    = COLLECT;
          byte_idx_d = '0;
          first_d    = 1'b1;
        end
      end
      COLLECT: begin
        if (i_rx_dv) begin
          last_bytes_d = {last_bytes_q[7:0], i_rx_byte};
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = '0;
            if (push_ok) begin
              push    = 1'b1;
              first_d = 1'b0;
            end else begin
              state_d = DISCARD;
              if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
        // End is judged after the same-cycle byte has been absorbed.
        if (csn_end) begin
          if (state_d == COLLECT && byte_idx_d != '0) frame_err_d = 1'b1;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (i_rx_dv) last_bytes_d = {last_bytes_q[7:0], i_rx_byte};
        if (csn_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      csn_meta_q   <= 1'b1;
      csn_s_q      <= 1'b1;
      csn_prev_q   <= 1'b1;
      state_q      <= IDLE;
      byte_idx_q   <= '0;
      first_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      frame_err_q  <= 1'b0;
      ovf_cnt_q    <= '0;
      last_bytes_q <= '0;
    end else begin
      csn_meta_q   <= i_csn;
      csn_s_q      <= csn_meta_q;
      csn_prev_q   <= csn_s_q;
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      first_q      <= first_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      frame_err_q  <= frame_err_d;
      ovf_cnt_q    <= ovf_cnt_d;
      last_bytes_q <= last_bytes_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {first_q, new_word};
  end

  assign o_word_valid = valid;
  assign o_word       = valid ? mem_q[rd_ptr_q][WW-1:0] : '0;
  assign o_word_first = valid & mem_q[rd_ptr_q][WW];
  assign o_level      = level_q;
  assign o_frame_err  = frame_err_q;
  assign o_ovf_cnt    = ovf_cnt_q;
  assign o_last_bytes = last_bytes_q;

endmodule

// File: tb/tb_spi_rx_word_fifo.sv
// Randomized frame traffic checked every cycle against a queue-based frame model,
// plus a directed wrap-around sequence on a one-byte-word, two-deep instance.
module tb_spi_rx_word_fifo;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [7:0]  rx_byte;
  logic        rx_dv, csn, word_ready;
  logic [15:0] word;
  logic        word_first, word_valid, frame_err;
  logic [3:0]  level;
  logic [7:0]  ovf_cnt;
  logic [15:0] last_bytes;

  logic [7:0]  byte2;
  logic        dv2, csn2, ready2;
  logic [7:0]  w2;
  logic        first2, valid2, err2;
  logic [1:0]  level2;
  logic [7:0]  ovf2;
  logic [15:0] last2;

  spi_rx_word_fifo #(.BYTES_PER_WORD(2), .FIFO_DEPTH(8), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .i_rx_byte(rx_byte), .i_rx_dv(rx_dv), .i_csn(csn),
    .o_word(word), .o_word_first(word_first), .o_word_valid(word_valid),
    .i_word_ready(word_ready), .o_level(level), .o_frame_err(frame_err),
    .o_ovf_cnt(ovf_cnt), .o_last_bytes(last_bytes)
  );

  spi_rx_word_fifo #(.BYTES_PER_WORD(1), .FIFO_DEPTH(2), .CNT_W(8)) dut_w1 (
    .clk(clk), .rstn(rstn), .i_rx_byte(byte2), .i_rx_dv(dv2), .i_csn(csn2),
    .o_word(w2), .o_word_first(first2), .o_word_valid(valid2),
    .i_word_ready(ready2), .o_level(level2), .o_frame_err(err2),
    .o_ovf_cnt(ovf2), .o_last_bytes(last2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame-level view with queues
  localparam int BPW   = 2;
  localparam int DEPTH = 8;
  bit          m_in_frame, m_drop, m_first, m_err;
  logic [7:0]  m_cur[$];
  logic [16:0] m_fifo[$];
  int          m_ovf;
  logic [15:0] m_last;
  bit          h0, h1, h2;   // i_csn sampled 1, 2, 3 edges ago

  task automatic model_reset();
    m_in_frame = 0; m_drop = 0; m_first = 0; m_err = 0;
    m_cur.delete(); m_fifo.delete();
    m_ovf = 0; m_last = '0;
    h0 = 1; h1 = 1; h2 = 1;
  endtask

  task automatic model_edge(input logic dv, input logic [7:0] b, input logic cs, input logic rdy);
    bit start, fin, pop, full, do_push, err_n;
    logic [15:0] w;
    logic [16:0] pw;
    start = h2 && !h1;
    fin   = !h2 && h1;
    pop   = (m_fifo.size() > 0) && rdy;
    full  = (m_fifo.size() == DEPTH);
    do_push = 0; err_n = 0; pw = '0;
    if (m_in_frame) begin
      if (dv) begin
        m_last = {m_last[7:0], b};
        if (!m_drop) begin
          m_cur.push_back(b);
          if (m_cur.size() == BPW) begin
            w = '0;
            foreach (m_cur[i]) w = (w << 8) | 16'(m_cur[i]);
            m_cur.delete();
            if (!full || pop) begin
              do_push = 1; pw = {m_first, w}; m_first = 0;
            end else begin
              if (m_ovf < 255) m_ovf++;
              m_drop = 1;
            end
          end
        end
      end
      if (fin) begin
        if (!m_drop && m_cur.size() != 0) err_n = 1;
        m_in_frame = 0; m_drop = 0; m_cur.delete();
      end
    end else if (start) begin
      m_in_frame = 1; m_first = 1; m_cur.delete();
    end
    if (pop) void'(m_fifo.pop_front());
    if (do_push) m_fifo.push_back(pw);
    m_err = err_n;
    h2 = h1; h1 = h0; h0 = cs;
  endtask

  task automatic compare_all();
    bit v;
    v = (m_fifo.size() > 0);
    check_eq("valid", word_valid, v);
    check_eq("level", level, m_fifo.size());
    check_eq("word", word, v ? m_fifo[0][15:0] : 16'h0);
    check_eq("first", word_first, v ? m_fifo[0][16] : 1'b0);
    check_eq("frame_err", frame_err, m_err);
    check_eq("ovf_cnt", ovf_cnt, m_ovf);
    check_eq("last_bytes", last_bytes, m_last);
  endtask

  // Called at a negedge; applies inputs across one rising edge, then checks.
  task automatic step(input logic dv, input logic [7:0] b, input logic cs, input logic rdy);
    rx_dv = dv; rx_byte = b; csn = cs; word_ready = rdy;
    model_edge(dv, b, cs, rdy);
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_main"}, {word, word_first, word_valid, level, frame_err, ovf_cnt, last_bytes}, 0);
    check_eq({tag, "_w1"}, {w2, first2, valid2, level2, err2, ovf2, last2}, 0);
  endtask

  logic [7:0] frame_bytes[$];

  function automatic logic pick_ready(input int rmode);
    case (rmode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return ($urandom_range(0, 7) == 0);
    endcase
  endfunction

  task automatic run_frame(input int rmode, input bit do_rst);
    repeat (2) step($urandom_range(0, 3) == 0, 8'($urandom), 1'b1, pick_ready(rmode));
    repeat (3) step($urandom_range(0, 3) == 0, 8'($urandom), 1'b0, pick_ready(rmode));
    foreach (frame_bytes[i]) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, 1'b0, pick_ready(rmode));
      step(1'b1, frame_bytes[i], 1'b0, pick_ready(rmode));
      if (do_rst && i == 8) begin
        rstn = 1'b0; csn = 1'b1; rx_dv = 1'b0; word_ready = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
    end
    repeat ($urandom_range(0, 4)) step($urandom_range(0, 1) == 1, 8'($urandom), 1'b1, pick_ready(rmode));
    repeat (3) step(1'b0, 8'h00, 1'b1, pick_ready(rmode));
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && m_fifo.size() > 0; k++) step(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic random_bytes(input int n);
    frame_bytes.delete();
    for (int i = 0; i < n; i++) frame_bytes.push_back(8'($urandom));
  endtask

  // Directed stimulus for the one-byte-word, two-deep instance
  logic [8:0] exp2[$];
  int         n_pop2 = 0;

  task automatic step2(input logic dv, input logic [7:0] b, input logic cs, input logic rdy);
    dv2 = dv; byte2 = b; csn2 = cs; ready2 = rdy;
    if (valid2 && ready2) begin
      if (exp2.size() == 0) begin
        check_eq("w1_pop_empty", valid2, 1'b0);
      end else begin
        check_eq("w1_word", {first2, w2}, exp2.pop_front());
        n_pop2++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d2[5];
    rstn = 1'b0; csn = 1'b1; rx_dv = 1'b0; rx_byte = '0; word_ready = 1'b0;
    csn2 = 1'b1; dv2 = 1'b0; byte2 = '0; ready2 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    frame_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_frame(1, 1'b0);
    frame_bytes = '{8'hAA, 8'hBB, 8'hCC};
    run_frame(1, 1'b0);
    random_bytes(22);
    run_frame(0, 1'b0);
    random_bytes(6);
    run_frame(3, 1'b0);
    drain();
    random_bytes(14);
    run_frame(0, 1'b1);

    for (int f = 0; f < 40; f++) begin
      int rmode;
      rmode = $urandom_range(0, 3);
      random_bytes($urandom_range(0, 24));
      run_frame(rmode, rmode == 0 && $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();

    d2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    repeat (3) step2(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) step2(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step2(1'b1, d2[i], 1'b0, 1'b0);
      exp2.push_back({i == 0, d2[i]});
      if (i % 2 == 1 || i == 4) begin
        check_eq("w1_level", level2, exp2.size());
        for (int k = 0; k < 4 && exp2.size() > 0; k++) step2(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("w1_level_drained", level2, 0);
      end
    end
    repeat (4) step2(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("w1_pop_count", n_pop2, 5);
    check_eq("w1_ovf", ovf2, 0);
    check_eq("w1_last", last2, 16'h4455);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
